// File: rtl/vga_pattern_sync.sv
// vga_pattern_sync: VGA timing generator with built-in test patterns.
// Horizontal and vertical counters produce px/py, syncs and blanking. Colour
// comes from the host (mode 0) or from one of three internal patterns: gray
// ramp, eight colour bars or checkerboard. Every visible output is
// registered, so it lags the counter state by exactly one cycle.
// The pattern mode is taken only at the first pixel of a frame, so a frame
// never mixes two patterns.
// Optional feature: define VGA_PATGEN_BORDER_EN to paint a one-pixel
// all-ones border around the active area in every mode.
module vga_pattern_sync #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLOR_W  = 10,
  parameter int CHK_LOG2 = 5
) (
  input  logic               iCLK,
  input  logic               iRST,
  input  logic [1:0]         iMode,
  input  logic [COLOR_W-1:0] iRed,
  input  logic [COLOR_W-1:0] iGreen,
  input  logic [COLOR_W-1:0] iBlue,
  output logic [9:0]         px,
  output logic [9:0]         py,
  output logic [COLOR_W-1:0] VGA_R,
  output logic [COLOR_W-1:0] VGA_G,
  output logic [COLOR_W-1:0] VGA_B,
  output logic               VGA_H_SYNC,
  output logic               VGA_V_SYNC,
  output logic               VGA_BLANK,
  output logic               VGA_SYNC,
  output logic               oFrameStart,
  output logic [15:0]        oFrameCnt
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  // Counter state
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_wrap, v_wrap;

  // Decoded timing for the current counter state
  logic          active;
  logic          at_origin;
  logic          hsync_low;
  logic          vsync_low;
  logic [1:0]    mode_q, mode_cur;

  // Pattern generation
  logic [12:0]        px_x8;
  logic [2:0]         bar_idx;
  logic [2:0]         bar;
  logic               chk_bit;
  logic [COLOR_W-1:0] ones;
  logic [COLOR_W-1:0] gray;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

  // Registered outputs
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic               blank_q, hs_q, vs_q, fs_q;
  logic [15:0]        fcnt_q;

  // Next-state of the raster counters: h wraps every line, v on each h wrap
  always_comb begin
    h_wrap = (hcnt_q == HW'(H_TOT - 1));
    v_wrap = (vcnt_q == VW'(V_TOT - 1));
    hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_wrap) begin
      vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;
    end
  end

  // Raster counters; reset restarts the frame at the origin
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  // Timing decode and the coordinate outputs (zero outside the visible area)
  always_comb begin
    active    = (hcnt_q < HW'(H_ACTIVE)) && (vcnt_q < VW'(V_ACTIVE));
    at_origin = (hcnt_q == '0) && (vcnt_q == '0);
    hsync_low = (hcnt_q >= HW'(H_ACTIVE + H_FP)) &&
                (hcnt_q <  HW'(H_ACTIVE + H_FP + H_SYNC));
    vsync_low = (vcnt_q >= VW'(V_ACTIVE + V_FP)) &&
                (vcnt_q <  VW'(V_ACTIVE + V_FP + V_SYNC));
    px        = active ? 10'(hcnt_q) : 10'd0;
    py        = active ? 10'(vcnt_q) : 10'd0;
    // The origin pixel already uses the incoming mode, so it belongs to the new frame.
    mode_cur  = at_origin ? iMode : mode_q;
  end

  // Pattern colour for the current pixel
  always_comb begin
    ones  = '1;
    gray  = COLOR_W'(px);
    px_x8 = {px, 3'b000};
    // Bar index = floor(px*8/H_ACTIVE), built from seven constant thresholds.
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (px_x8 >= 13'(k * H_ACTIVE)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
    bar     = 3'd7 - bar_idx;
    chk_bit = px[CHK_LOG2] ^ py[CHK_LOG2];

    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      case (mode_cur)
        2'd0: begin
          r_d = iRed;
          g_d = iGreen;
          b_d = iBlue;
        end
        2'd1: begin
          r_d = gray;
          g_d = gray;
          b_d = gray;
        end
        2'd2: begin
          r_d = bar[2] ? ones : '0;
          g_d = bar[1] ? ones : '0;
          b_d = bar[0] ? ones : '0;
        end
        default: begin
          r_d = chk_bit ? ones : '0;
          g_d = chk_bit ? ones : '0;
          b_d = chk_bit ? ones : '0;
        end
      endcase
`ifdef VGA_PATGEN_BORDER_EN
      if ((hcnt_q == '0) || (hcnt_q == HW'(H_ACTIVE - 1)) ||
          (vcnt_q == '0) || (vcnt_q == VW'(V_ACTIVE - 1))) begin
        r_d = ones;
        g_d = ones;
        b_d = ones;
      end
`else
      // No border: the pattern covers every active pixel.
`endif
    end
  end

  // Output register stage: colour, blank, syncs, frame pulse/counter, mode latch
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      blank_q <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      fcnt_q  <= '0;
      mode_q  <= 2'd0;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      blank_q <= active;
      hs_q    <= ~hsync_low;
      vs_q    <= ~vsync_low;
      fs_q    <= at_origin;
      fcnt_q  <= at_origin ? fcnt_q + 16'd1 : fcnt_q;
      mode_q  <= mode_cur;
    end
  end

  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_BLANK   = blank_q;
  assign VGA_H_SYNC  = hs_q;
  assign VGA_V_SYNC  = vs_q;
  assign VGA_SYNC    = 1'b0;
  assign oFrameStart = fs_q;
  assign oFrameCnt   = fcnt_q;

endmodule

// File: tb/tb_vga_pattern_sync.sv
// tb_vga_pattern_sync: self-checking bench for vga_pattern_sync.
// Uses a reduced raster (128x50 total, 100x40 visible, 6-bit colour, 8 px
// checker cells) so several whole frames fit in a short run. The reference
// model derives every output from the raster position with plain arithmetic.
module tb_vga_pattern_sync;

  localparam int HA = 100, HFP = 6, HS = 12, HBP = 10;
  localparam int VA = 40,  VFP = 3, VS = 2,  VBP = 5;
  localparam int CW = 6, CHK = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam int EW = 3 * CW + 4 + 16;
  localparam logic [EW-1:0] RST_EXP = {{(3*CW){1'b0}}, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0};

  // Clock and DUT signals
  logic          clk = 1'b0;
  logic          iRST = 1'b1;
  logic [1:0]    iMode = 2'd0;
  logic [CW-1:0] iRed = '0, iGreen = '0, iBlue = '0;
  logic [9:0]    px, py;
  logic [CW-1:0] VGA_R, VGA_G, VGA_B;
  logic          VGA_H_SYNC, VGA_V_SYNC, VGA_BLANK, VGA_SYNC, oFrameStart;
  logic [15:0]   oFrameCnt;

  always #5 clk = ~clk;

  vga_pattern_sync #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .COLOR_W(CW), .CHK_LOG2(CHK)
  ) dut (
    .iCLK(clk), .iRST(iRST), .iMode(iMode),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .px(px), .py(py),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_H_SYNC(VGA_H_SYNC), .VGA_V_SYNC(VGA_V_SYNC),
    .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC),
    .oFrameStart(oFrameStart), .oFrameCnt(oFrameCnt)
  );

  // Scoreboard state
  int pass_cnt = 0;
  int total_cnt = 0;
  logic [EW-1:0] exp_q[$];

  // Reference model state: position in frame, latched mode, frame count
  int          n = 0;
  logic [1:0]  mode_lat = 2'd0;
  logic [15:0] fcnt_m = 16'd0;
  bit          model_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
  endtask

  function automatic logic [3*CW-1:0] model_rgb(input int h, input int v, input int mode,
                                               input logic [CW-1:0] hr, hg, hb);
    logic [CW-1:0] ones, gv, zero;
    int bar;
    ones = '1;
    zero = '0;
    if (h >= HA || v >= VA) return '0;
`ifdef VGA_PATGEN_BORDER_EN
    if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) return {ones, ones, ones};
`endif
    case (mode)
      0: return {hr, hg, hb};
      1: begin
        gv = CW'(h % (1 << CW));
        return {gv, gv, gv};
      end
      2: begin
        bar = 7 - (h * 8) / HA;
        return {(bar[2] ? ones : zero), (bar[1] ? ones : zero), (bar[0] ? ones : zero)};
      end
      default: return ((((h >> CHK) ^ (v >> CHK)) & 1) != 0) ? {ones, ones, ones} : '0;
    endcase
  endfunction

  function automatic logic [EW-1:0] model_out(input int h, input int v, input int mode,
                                              input logic [CW-1:0] hr, hg, hb,
                                              input logic [15:0] fc);
    logic blank, hs, vs, fs;
    blank = (h < HA) && (v < VA);
    hs    = !((h >= HA + HFP) && (h < HA + HFP + HS));
    vs    = !((v >= VA + VFP) && (v < VA + VFP + VS));
    fs    = (h == 0) && (v == 0);
    return {model_rgb(h, v, mode, hr, hg, hb), blank, hs, vs, fs, fc};
  endfunction

  // One clock: drive inputs, predict, advance, compare registered outputs.
  task automatic cycle(input logic rst, input logic [1:0] mode,
                       input logic [CW-1:0] r, g, b);
    int h, v;
    logic [9:0] epx, epy;
    logic [EW-1:0] e, got;
    iRST = rst; iMode = mode; iRed = r; iGreen = g; iBlue = b;
    h = n % HT;
    v = n / HT;
    if (model_valid) begin
      epx = (h < HA && v < VA) ? 10'(h) : 10'd0;
      epy = (h < HA && v < VA) ? 10'(v) : 10'd0;
      chk("px", px, epx);
      chk("py", py, epy);
    end
    if (rst) begin
      e = RST_EXP;
      n = 0;
      mode_lat = 2'd0;
      fcnt_m = 16'd0;
      model_valid = 1'b1;
    end else begin
      if (h == 0 && v == 0) begin
        mode_lat = mode;
        fcnt_m = fcnt_m + 16'd1;
      end
      e = model_out(h, v, mode_lat, r, g, b, fcnt_m);
      n = (n + 1) % FRAME;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    got = {VGA_R, VGA_G, VGA_B, VGA_BLANK, VGA_H_SYNC, VGA_V_SYNC, oFrameStart, oFrameCnt};
    chk("out", got, exp_q.pop_front());
  endtask

  task automatic reset3();
    repeat (3) cycle(1'b1, 2'd0, '0, '0, '0);
  endtask

  // Directed pixel vectors
  typedef struct {
    int x; int y; int mode;
    logic [CW-1:0] hr, hg, hb;
    logic [CW-1:0] er, eg, eb;
    logic eblank;
  } vec_t;

  vec_t vecs[19];

  function automatic bit is_edge(input int x, input int y);
    return (x < HA) && (y < VA) && (x == 0 || x == HA - 1 || y == 0 || y == VA - 1);
  endfunction

  task automatic run_vectors();
    logic [3*CW-1:0] e;
    logic [CW-1:0] ones;
    int nn;
    ones = '1;
    vecs[0]  = '{7, 0, 3,   6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b1};
    vecs[1]  = '{8, 0, 3,   6'h00, 6'h00, 6'h00,  6'h3F, 6'h3F, 6'h3F, 1'b1};
    vecs[2]  = '{8, 8, 3,   6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b1};
    vecs[3]  = '{0, 10, 2,  6'h00, 6'h00, 6'h00,  6'h3F, 6'h3F, 6'h3F, 1'b1};
    vecs[4]  = '{12, 10, 2, 6'h00, 6'h00, 6'h00,  6'h3F, 6'h3F, 6'h3F, 1'b1};
    vecs[5]  = '{13, 10, 2, 6'h00, 6'h00, 6'h00,  6'h3F, 6'h3F, 6'h00, 1'b1};
    vecs[6]  = '{50, 10, 2, 6'h00, 6'h00, 6'h00,  6'h00, 6'h3F, 6'h3F, 1'b1};
    vecs[7]  = '{87, 10, 2, 6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h3F, 1'b1};
    vecs[8]  = '{99, 10, 2, 6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b1};
    vecs[9]  = '{63, 5, 1,  6'h00, 6'h00, 6'h00,  6'h3F, 6'h3F, 6'h3F, 1'b1};
    vecs[10] = '{64, 5, 1,  6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b1};
    vecs[11] = '{70, 5, 1,  6'h00, 6'h00, 6'h00,  6'h06, 6'h06, 6'h06, 1'b1};
    vecs[12] = '{5, 5, 0,   6'h12, 6'h34, 6'h21,  6'h12, 6'h34, 6'h21, 1'b1};
    vecs[13] = '{5, 5, 0,   6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b1};
    vecs[14] = '{0, 5, 0,   6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b1};
    vecs[15] = '{99, 5, 0,  6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b1};
    vecs[16] = '{5, 39, 0,  6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b1};
    vecs[17] = '{100, 5, 3, 6'h00, 6'h00, 6'h00,  6'h00, 6'h00, 6'h00, 1'b0};
    vecs[18] = '{5, 40, 0,  6'h3F, 6'h3F, 6'h3F,  6'h00, 6'h00, 6'h00, 1'b0};
    for (int i = 0; i < 19; i++) begin
      reset3();
      nn = vecs[i].y * HT + vecs[i].x;
      for (int k = 0; k <= nn; k++)
        cycle(1'b0, 2'(vecs[i].mode), vecs[i].hr, vecs[i].hg, vecs[i].hb);
      e = {vecs[i].er, vecs[i].eg, vecs[i].eb};
`ifdef VGA_PATGEN_BORDER_EN
      if (is_edge(vecs[i].x, vecs[i].y)) e = {ones, ones, ones};
`endif
      chk($sformatf("vec%0d_rgb", i), {VGA_R, VGA_G, VGA_B}, e);
      chk($sformatf("vec%0d_blank", i), VGA_BLANK, vecs[i].eblank);
    end
  endtask

  // Sync widths, frame pulse spacing, frame count, mid-line reset
  task automatic run_timing();
    int hs_low, hs_first, vs_low, fs_cnt;
    int fs_pos[2];
    logic [1:0] m;
    hs_low = 0; hs_first = -1; vs_low = 0; fs_cnt = 0;
    fs_pos[0] = -1; fs_pos[1] = -1;
    m = 2'($urandom_range(0, 3));
    reset3();
    for (int k = 0; k < 2 * FRAME; k++) begin
      cycle(1'b0, m, CW'($urandom), CW'($urandom), CW'($urandom));
      if (k < HT && !VGA_H_SYNC) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (k < FRAME && !VGA_V_SYNC) vs_low++;
      if (oFrameStart) begin
        if (fs_cnt < 2) fs_pos[fs_cnt] = k;
        fs_cnt++;
      end
    end
    chk("hsync_low_len", hs_low, HS);
    chk("hsync_first_low", hs_first, HA + HFP);
    chk("vsync_low_len", vs_low, VS * HT);
    chk("frame_pulses", fs_cnt, 2);
    chk("frame_spacing", fs_pos[1] - fs_pos[0], FRAME);
    chk("frame_cnt", oFrameCnt, 2);
    // Reset lands inside the horizontal sync pulse of line 0.
    for (int k = 0; k < 110; k++) cycle(1'b0, m, '0, '0, '0);
    cycle(1'b1, m, '0, '0, '0);
    chk("midline_rst",
        {VGA_R, VGA_G, VGA_B, VGA_BLANK, VGA_H_SYNC, VGA_V_SYNC, oFrameStart, oFrameCnt},
        RST_EXP);
    cycle(1'b0, m, '0, '0, '0);
    chk("post_rst_fs", oFrameStart, 1'b1);
    chk("post_rst_fcnt", oFrameCnt, 16'd1);
    chk("post_rst_hsync", VGA_H_SYNC, 1'b1);
  endtask

  // Mode change mid-frame takes effect at the next frame only
  task automatic run_mode_switch();
    int nt;
    logic [1:0] m;
    nt = 25 * HT + 30;
    reset3();
    for (int k = 0; k <= FRAME + nt; k++) begin
      m = (k < 20 * HT) ? 2'd1 : 2'd0;
      cycle(1'b0, m, 6'h15, 6'h2A, 6'h0F);
      if (k == nt) chk("switch_gray", {VGA_R, VGA_G, VGA_B}, {6'd30, 6'd30, 6'd30});
      if (k == FRAME + nt) chk("switch_host", {VGA_R, VGA_G, VGA_B}, {6'h15, 6'h2A, 6'h0F});
    end
  endtask

  // Random modes, host colours and occasional resets against the model
  task automatic run_random();
    logic [1:0] m;
    logic rst;
    m = 2'($urandom_range(0, 3));
    reset3();
    for (int k = 0; k < 3 * FRAME; k++) begin
      if ($urandom_range(0, 599) == 0) m = 2'($urandom_range(0, 3));
      rst = ($urandom_range(0, 4999) == 0);
      cycle(rst, m, CW'($urandom), CW'($urandom), CW'($urandom));
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    run_vectors();
    run_timing();
    run_mode_switch();
    run_random();
    chk("vga_sync_const", VGA_SYNC, 1'b0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
